bcd_display_scanner: RTL and testbench



---
 rtl/bcd_display_if.sv | 24 ++
 rtl/bcd_display_scanner.sv | 107 ++++++++++
 tb/tb_bcd_display_scanner.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/bcd_display_if.sv
// Port bundle between a decade-counter chain and the multiplexed 7-segment scanner.
// The master supplies the digits and controls; the slave drives the display.
interface bcd_display_if #(
    parameter int DIGITS = 4
);
    logic [4*DIGITS-1:0] bcd_in;
    logic [DIGITS-1:0]   dp_in;
    logic                load;
    logic                blank_lz;
    logic [6:0]          seg;
    logic                dp;
    logic [DIGITS-1:0]   an;
    logic                frame_done;

    modport master (
        output bcd_in, dp_in, load, blank_lz,
        input  seg, dp, an, frame_done
    );

    modport slave (
        input  bcd_in, dp_in, load, blank_lz,
        output seg, dp, an, frame_done
    );
endinterface

// File: rtl/bcd_display_scanner.sv
// Snapshots BCD digits on load and scans them onto one common-cathode display,
// PRESCALE cycles per digit, with optional leading-zero blanking.
module bcd_display_scanner #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 1000
) (
    input  logic          clk,
    input  logic          rst,
    bcd_display_if.slave  bus
);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);
    localparam logic [PW-1:0] LAST_PRE = PW'(PRESCALE - 1);
    localparam logic [DIGITS-1:0] AN_ONE = {{(DIGITS-1){1'b0}}, 1'b1};

    logic [3:0]        snap_r [DIGITS];
    logic [DIGITS-1:0] snap_dp_r;
    logic [PW-1:0]     presc_r;
    logic [IW-1:0]     idx_r;
    logic              wrap_r;
    logic [6:0]        seg_r;
    logic              dp_r;
    logic [DIGITS-1:0] an_r;
    logic              frame_done_r;

    logic              zero_run_s;
    logic              blank_s;
    logic [6:0]        seg_next_s;

    function automatic logic [6:0] decode_7seg(input logic [3:0] code);
        logic [6:0] pattern;
        case (code)
            4'd0:    pattern = 7'h3F;
            4'd1:    pattern = 7'h06;
            4'd2:    pattern = 7'h5B;
            4'd3:    pattern = 7'h4F;
            4'd4:    pattern = 7'h66;
            4'd5:    pattern = 7'h6D;
            4'd6:    pattern = 7'h7D;
            4'd7:    pattern = 7'h07;
            4'd8:    pattern = 7'h7F;
            4'd9:    pattern = 7'h6F;
            default: pattern = 7'h40;
        endcase
        return pattern;
    endfunction

    // Segment pattern for the current digit; blank it when it sits inside a run of leading zeros.
    always_comb begin
        zero_run_s = 1'b1;
        blank_s    = 1'b0;
        for (int i = DIGITS - 1; i > 0; i--) begin
            zero_run_s = zero_run_s & (snap_r[i] == 4'd0);
            blank_s    = (IW'(i) == idx_r) ? zero_run_s : blank_s;
        end
        if (bus.blank_lz && blank_s) begin
            seg_next_s = 7'h00;
        end else begin
            seg_next_s = decode_7seg(snap_r[idx_r]);
        end
    end

    // Snapshot capture, prescaler/index stepping and registered display outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DIGITS; i++) begin
                snap_r[i] <= 4'd0;
            end
            snap_dp_r    <= '0;
            presc_r      <= '0;
            idx_r        <= '0;
            wrap_r       <= 1'b0;
            seg_r        <= 7'h00;
            dp_r         <= 1'b0;
            an_r         <= '0;
            frame_done_r <= 1'b0;
        end else begin
            if (bus.load) begin
                for (int i = 0; i < DIGITS; i++) begin
                    snap_r[i] <= bus.bcd_in[4*i +: 4];
                end
                snap_dp_r <= bus.dp_in;
            end

            if (presc_r == LAST_PRE) begin
                presc_r <= '0;
                idx_r   <= (idx_r == LAST_IDX) ? '0 : idx_r + IW'(1);
                wrap_r  <= (idx_r == LAST_IDX);
            end else begin
                presc_r <= presc_r + PW'(1);
                wrap_r  <= 1'b0;
            end

            // wrap_r lags the index by one edge, so the pulse lands on digit 0's first output cycle.
            seg_r        <= seg_next_s;
            dp_r         <= snap_dp_r[idx_r];
            an_r         <= AN_ONE << idx_r;
            frame_done_r <= wrap_r;
        end
    end

    assign bus.seg        = seg_r;
    assign bus.dp         = dp_r;
    assign bus.an         = an_r;
    assign bus.frame_done = frame_done_r;
endmodule

// File: tb/tb_bcd_display_scanner.sv
// Scoreboard bench: a time-based reference model queues the expected display state per edge;
// a monitor pops and compares after every rising edge.
module tb_bcd_display_scanner;
    localparam int D = 4;
    localparam int P = 4;

    typedef struct packed {
        logic [6:0]   seg;
        logic         dp;
        logic [D-1:0] an;
        logic         fd;
    } exp_t;

    localparam logic [6:0] SEG_LUT [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40
    };

    logic clk = 1'b0;
    logic rst = 1'b1;
    bcd_display_if #(.DIGITS(D)) bus ();

    bcd_display_scanner #(.DIGITS(D), .PRESCALE(P)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    exp_t q[$];
    int checks = 0;
    int fails  = 0;

    // Reference model state: snapshot contents and edges since reset release.
    int m_snap [D];
    bit m_dp   [D];
    int m_cyc  = 0;

    task automatic step(input bit r, input bit l, input logic [15:0] b,
                        input logic [3:0] d, input bit blz);
        exp_t e;
        int pos, dig;
        bit lz;
        @(negedge clk);
        rst          = r;
        bus.load     = l;
        bus.bcd_in   = b;
        bus.dp_in    = d;
        bus.blank_lz = blz;
        if (r) begin
            e = '0;
            m_cyc = 0;
            for (int j = 0; j < D; j++) begin
                m_snap[j] = 0;
                m_dp[j]   = 1'b0;
            end
        end else begin
            m_cyc++;
            pos = m_cyc - 1;
            dig = (pos / P) % D;
            lz  = 1'b1;
            for (int j = D - 1; j >= dig; j--) lz = lz && (m_snap[j] == 0);
            e.seg = (blz && dig > 0 && lz) ? 7'h00 : SEG_LUT[m_snap[dig]];
            e.dp  = m_dp[dig];
            e.an  = D'(1 << dig);
            e.fd  = (pos > 0) && (pos % (P * D) == 0);
            if (l) begin
                for (int j = 0; j < D; j++) begin
                    m_snap[j] = int'(b[4*j +: 4]);
                    m_dp[j]   = d[j];
                end
            end
        end
        q.push_back(e);
    endtask

    task automatic idle(input int n, input bit blz);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 16'($urandom), 4'($urandom), blz);
    endtask

    // Monitor: compare the DUT outputs against the oldest queued expectation after each edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (bus.seg !== e.seg || bus.dp !== e.dp || bus.an !== e.an ||
                    bus.frame_done !== e.fd) begin
                    fails++;
                    $display("FAIL display t=%0t got seg=%h dp=%b an=%b fd=%b, expected seg=%h dp=%b an=%b fd=%b",
                             $time, bus.seg, bus.dp, bus.an, bus.frame_done,
                             e.seg, e.dp, e.an, e.fd);
                end
            end
        end
    end

    initial begin
        logic [15:0] rb;
        bus.load     = 1'b0;
        bus.bcd_in   = 16'h0000;
        bus.dp_in    = 4'b0000;
        bus.blank_lz = 1'b0;

        // Reset, then a full frame plus wrap with an all-zero snapshot.
        step(1'b1, 1'b0, 16'h0000, 4'b0000, 1'b0);
        step(1'b1, 1'b1, 16'h9999, 4'b1111, 1'b0);
        idle(20, 1'b0);

        // Mixed digits with one decimal point.
        step(1'b0, 1'b1, 16'h1905, 4'b0100, 1'b0);
        idle(17, 1'b0);

        // Leading-zero blanking on and off.
        step(1'b0, 1'b1, 16'h0007, 4'b0000, 1'b1);
        idle(17, 1'b1);
        idle(16, 1'b0);

        // Invalid code counts as non-zero for blanking.
        step(1'b0, 1'b1, 16'h0A00, 4'b1001, 1'b1);
        idle(17, 1'b1);

        // Load on the same edge the index steps 0 -> 1.
        step(1'b1, 1'b0, 16'h0000, 4'b0000, 1'b0);
        idle(3, 1'b0);
        step(1'b0, 1'b1, 16'h2468, 4'b0010, 1'b0);
        idle(6, 1'b0);

        // Reset while digit 2 is lit, then restart from digit 0.
        step(1'b1, 1'b0, 16'h0000, 4'b0000, 1'b0);
        step(1'b0, 1'b1, 16'h1234, 4'b0100, 1'b0);
        idle(9, 1'b0);
        step(1'b1, 1'b1, 16'h5678, 4'b1111, 1'b0);
        idle(6, 1'b0);

        // Randomised traffic, biased towards zero digits to exercise blanking.
        for (int k = 0; k < 800; k++) begin
            rb = 16'($urandom);
            for (int j = 0; j < D; j++) begin
                if ($urandom_range(0, 2) == 0) rb[4*j +: 4] = 4'd0;
            end
            step($urandom_range(0, 99) == 0, $urandom_range(0, 7) == 0, rb,
                 4'($urandom), 1'($urandom));
        end

        @(posedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain got %0d pending entries, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
